// File: rtl/serial_subtractor_ctrl_pkg.sv
// Purpose: shared state encoding and counter sizing for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_subtractor_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bit counter width: must hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (clog2(width) < 1) ? 1 : clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_full_subtractor_cell.sv
// Purpose: 1-bit full subtractor (x - y - c) built from two half-subtractor stages.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle.
//
// Ports:
//   x, y, c : minuend bit, subtrahend bit, borrow-in
//   d, bo   : difference bit, borrow-out
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First half subtractor: x - y.
    assign hs1_d = x ^ y;
    assign hs1_b = ~x & y;

    // Second half subtractor: (x - y) - c.
    assign d     = hs1_d ^ c;
    assign hs2_b = ~hs1_d & c;

    // Only one stage can borrow at a time, so OR merges them.
    assign bo    = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Purpose: bit-serial WIDTH-bit subtractor, diff = a - b - bin, one bit per cycle LSB first.
// Latency: done pulses in the cycle after edge E0+WIDTH (E0 = accepting start edge); one op per WIDTH+2 cycles.
// Backpressure: start is honoured only while ready (IDLE); starts during RUN/DONE are dropped, not queued.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start, a, b, bin  : request and operands, captured on the accepted start edge
//   ready, busy, done : IDLE indicator, RUN indicator, one-cycle result-valid pulse
//   diff, bout        : result and final borrow, held until the next done
//   ovf               : signed overflow flag, present only with SERIAL_SUB_SIGNED_OVF_EN defined
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor_cell u_cell (
        .x  (sha[0]),
        .y  (shb[0]),
        .c  (borrow),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: operands are only loaded in IDLE, so a start seen during
    // RUN/DONE cannot disturb the shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sha    <= '0;
            shb    <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sha    <= a;
                        shb    <= b;
                        borrow <= bin;
                        cnt    <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    res    <= {cell_d, res[WIDTH-1:1]};
                    sha    <= sha >> 1;
                    shb    <= shb >> 1;
                    borrow <= cell_bo;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // The bit being processed now is the MSB of the result.
                        diff <= {cell_d, res[WIDTH-1:1]};
                        bout <= cell_bo;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Purpose: self-checking bench for serial_subtractor_ctrl (WIDTH=8), scoreboard plus reference model.
// Latency: expects done WIDTH+1 cycles after the accepting start and a WIDTH+2 cycle op period.
// Backpressure: drives start freely, including during RUN/DONE where it must be ignored.
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             bin   = 1'b0;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        int               n;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int cyc      = 0;
    int last_acc = -1;
    int acc_cnt  = 0;
    bit b2b_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        cmp_cnt++;
        fail_cnt++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c, input int n);
        exp_t e;
        int   v;
        v    = int'(x) - int'(y) - int'(c);
        e.d  = WIDTH'(v & ((1 << WIDTH) - 1));
        e.bo = (v < 0);
        e.ov = (x[WIDTH-1] != y[WIDTH-1]) && (e.d[WIDTH-1] != x[WIDTH-1]);
        e.n  = n;
        return e;
    endfunction

    // Issue side: every start the DUT will accept pushes its expected result.
    always @(negedge clk) begin
        if (!rst && ready && start) begin
            if (b2b_mode) begin
                if (last_acc >= 0) check("b2b_interval", cyc - last_acc, WIDTH + 2);
                last_acc = cyc;
            end else begin
                last_acc = -1;
            end
            acc_cnt++;
            sbq.push_back(model(a, b, bin, cyc));
        end
    end

    // Monitor side: compares on done, checks result hold otherwise.
    bit               rst_prev = 1'b1;
    logic [WIDTH-1:0] held_d   = '0;
    logic             held_b   = 1'b0;
    logic             held_o   = 1'b0;
    int               busy_cnt = 0;

    always @(negedge clk) begin
        if (rst_prev) begin
            check("rst_ready", ready, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_diff", diff, 0);
            check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            check("rst_ovf", ovf, 0);
`endif
            held_d   = '0;
            held_b   = 1'b0;
            held_o   = 1'b0;
            busy_cnt = 0;
        end else if (done) begin
            if (sbq.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                mon_e = sbq.pop_front();
                check("sb_diff", diff, mon_e.d);
                check("sb_bout", bout, mon_e.bo);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                check("sb_ovf", ovf, mon_e.ov);
`endif
                check("done_latency", cyc - mon_e.n, WIDTH + 1);
                check("busy_cycles", busy_cnt, WIDTH);
                check("ready_in_done", ready, 0);
            end
            held_d   = diff;
            held_b   = bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            held_o   = ovf;
`endif
            busy_cnt = 0;
        end else begin
            check("diff_hold", diff, held_d);
            check("bout_hold", bout, held_b);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            check("ovf_hold", ovf, held_o);
`endif
        end
        if (busy) busy_cnt++;
        if (rst) sbq.delete();
        rst_prev = rst;
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!ready) fail_now("ready_timeout");
    endtask

    task automatic do_op_chk(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                             input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        int t;
        wait_ready();
        start = 1'b1;
        a     = x;
        b     = y;
        bin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
        t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            fail_now("done_timeout");
        end else begin
            check("dir_diff", diff, ed);
            check("dir_bout", bout, eb);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            check("dir_ovf", ovf, eo);
`else
            if (eo === 1'bx) fail_now("dir_ovf_arg");
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int acc0;
        int k;
        int t;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases.
        do_op_chk(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        do_op_chk(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        do_op_chk(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op_chk(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        do_op_chk(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        // Reset during RUN cycle 4 discards the operation.
        wait_ready();
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        bin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_diff", diff, 0);
        check("midrst_bout", bout, 0);
        seen = 0;
        repeat (12) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", seen, 0);
        do_op_chk(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

        // Start held high with operands changing every cycle.
        wait_ready();
        acc0     = acc_cnt;
        b2b_mode = 1'b1;
        start    = 1'b1;
        repeat (50) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            bin = 1'($urandom);
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        b2b_mode = 1'b0;
        check("b2b_accepts", acc_cnt - acc0, 5);

        // Random operations with start and operand noise during RUN.
        for (int i = 0; i < 1000; i++) begin
            wait_ready();
            start = 1'b1;
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            bin   = 1'($urandom);
            @(posedge clk);
            #1;
            k = $urandom_range(0, 6);
            repeat (k) begin
                start = 1'($urandom);
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                bin   = 1'($urandom);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end

        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("queue_drained", sbq.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
